// File: rtl/cc_line_serializer_p.sv
// Cache-line serializer: pops one {offset, line} FIFO entry and streams it as
// BEATS beats of BEAT_W bits, critical-word-first or linear, with rlast on the final beat.
module cc_line_serializer_p #(
    parameter int BEAT_W = 64,
    parameter int BEATS  = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          wrap_mode_i,
    input  logic                                          fifo_empty_i,
    input  logic [$clog2(BEAT_W*BEATS/8)+BEAT_W*BEATS-1:0] fifo_rdata_i,
    output logic                                          fifo_rden_o,
    output logic [BEAT_W-1:0]                             rdata_o,
    output logic                                          rlast_o,
    output logic                                          rvalid_o,
    input  logic                                          rready_i,
    output logic                                          busy_o
);
    // state | meaning
    // IDLE  | no line held; pop as soon as the FIFO has an entry
    // SEND  | line held; one beat per handshake, refill on the last-beat handshake

    localparam int LINE_W = BEAT_W * BEATS;
    localparam int OFS_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(BEATS);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   start_q, start_d;
    logic [IDX_W-1:0]   idx;
    logic               mode_q, mode_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [OFS_W-1:0]   ofs;
    logic               valid_q;
    logic               last;
    logic               hs;
    logic               pop;

    assign ofs     = fifo_rdata_i[OFS_W+LINE_W-1 -: OFS_W];
    assign valid_q = (state_q == SEND);

    // Sub-beat offset bits only matter for byte lanes, not for beat ordering.
    if (OFS_W > IDX_W) begin : g_ofs_lo
        logic unused_ofs_lo;
        assign unused_ofs_lo = ^ofs[OFS_W-IDX_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= '0;
            mode_q  <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            mode_q  <= mode_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        mode_d  = mode_q;
        line_d  = line_q;

        idx  = (mode_q ? start_q : '0) + cnt_q;
        last = valid_q && (cnt_q == IDX_W'(BEATS - 1));
        hs   = valid_q && !rst && rready_i;
        pop  = !rst && !fifo_empty_i && (!valid_q || (rready_i && last));

        if (hs) begin
            cnt_d = cnt_q + 1'b1;
            if (last) state_d = IDLE;
        end

        // A pop overrides the last-beat retire so the next line follows with no bubble.
        if (pop) begin
            state_d = SEND;
            cnt_d   = '0;
            line_d  = fifo_rdata_i[LINE_W-1:0];
            mode_d  = wrap_mode_i;
            start_d = wrap_mode_i ? ofs[OFS_W-1 -: IDX_W] : '0;
        end
    end

    assign fifo_rden_o = pop;
    assign rvalid_o    = valid_q && !rst;
    assign rlast_o     = last && !rst;
    assign busy_o      = rvalid_o;
    assign rdata_o     = rvalid_o ? line_q[idx*BEAT_W +: BEAT_W] : '0;

endmodule

// File: tb/tb_cc_line_serializer_p.sv
// Directed bench for cc_line_serializer_p: 64x8 instance for ordering, backpressure,
// back-to-back and reset; a 32x4 instance for the small-config wrap case.
module tb_cc_line_serializer_p;
    localparam int BW  = 64;
    localparam int NB  = 8;
    localparam int LW  = BW * NB;
    localparam int OW  = 6;
    localparam int BW2 = 32;
    localparam int NB2 = 4;
    localparam int LW2 = BW2 * NB2;
    localparam int OW2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              wrap_mode = 1'b0;
    logic              fifo_empty = 1'b1;
    logic [OW+LW-1:0]  fifo_rdata = '0;
    logic              fifo_rden;
    logic [BW-1:0]     rdata;
    logic              rlast, rvalid, busy;
    logic              rready = 1'b0;

    logic              wrap_mode2 = 1'b0;
    logic              fifo_empty2 = 1'b1;
    logic [OW2+LW2-1:0] fifo_rdata2 = '0;
    logic              fifo_rden2;
    logic [BW2-1:0]    rdata2;
    logic              rlast2, rvalid2, busy2;
    logic              rready2 = 1'b0;

    int total = 0;
    int bad   = 0;

    cc_line_serializer_p #(.BEAT_W(BW), .BEATS(NB)) dut (
        .clk(clk), .rst(rst), .wrap_mode_i(wrap_mode), .fifo_empty_i(fifo_empty),
        .fifo_rdata_i(fifo_rdata), .fifo_rden_o(fifo_rden), .rdata_o(rdata),
        .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready), .busy_o(busy)
    );

    cc_line_serializer_p #(.BEAT_W(BW2), .BEATS(NB2)) dut2 (
        .clk(clk), .rst(rst), .wrap_mode_i(wrap_mode2), .fifo_empty_i(fifo_empty2),
        .fifo_rdata_i(fifo_rdata2), .fifo_rden_o(fifo_rden2), .rdata_o(rdata2),
        .rlast_o(rlast2), .rvalid_o(rvalid2), .rready_i(rready2), .busy_o(busy2)
    );

    function automatic logic [LW-1:0] mk_line();
        logic [LW-1:0] l;
        for (int k = 0; k < NB; k++) l[k*BW +: BW] = BW'(k);
        return l;
    endfunction

    function automatic logic [LW2-1:0] mk_line2();
        logic [LW2-1:0] l;
        for (int k = 0; k < NB2; k++) l[k*BW2 +: BW2] = BW2'(k);
        return l;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        fifo_empty = 1'b0;
        fifo_rdata = {6'd16, mk_line()};
        rready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (fifo_rden !== 1'b0) begin
            bad++; $display("FAIL reset_rden: got %b want 0", fifo_rden);
        end
        @(negedge clk);
        rst = 1'b0;
        fifo_empty = 1'b1;
        #1;
        total++;
        if ({rvalid, rlast, fifo_rden, busy} !== 4'b0000 || rdata !== '0) begin
            bad++; $display("FAIL reset_outputs: v/l/rden/busy=%b rdata=%0h want 0000/0",
                            {rvalid, rlast, fifo_rden, busy}, rdata);
        end
        total++;
        if ({rvalid2, rlast2, fifo_rden2, busy2} !== 4'b0000 || rdata2 !== '0) begin
            bad++; $display("FAIL reset_outputs2: v/l/rden/busy=%b rdata=%0h want 0000/0",
                            {rvalid2, rlast2, fifo_rden2, busy2}, rdata2);
        end
    endtask

    // Pops one entry with rready held high and checks the full beat sequence.
    task automatic send_line(input logic [OW-1:0] ofs, input logic wrap, input int start,
                             input string nm);
        int exp_idx;
        @(negedge clk);
        wrap_mode = wrap;
        fifo_rdata = {ofs, mk_line()};
        fifo_empty = 1'b0;
        rready = 1'b1;
        #1;
        total++;
        if (fifo_rden !== 1'b1) begin
            bad++; $display("FAIL %s pop: rden=%b want 1", nm, fifo_rden);
        end
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            fifo_empty = 1'b1;
            wrap_mode = ~wrap;
            #1;
            exp_idx = (start + i) % NB;
            total++;
            if (rvalid !== 1'b1 || rdata !== BW'(exp_idx) || rlast !== (i == NB - 1)
                || fifo_rden !== 1'b0) begin
                bad++;
                $display("FAIL %s beat%0d: v=%b data=%0h last=%b rden=%b want 1/%0h/%b/0",
                         nm, i, rvalid, rdata, rlast, fifo_rden, exp_idx, (i == NB - 1));
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (rvalid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s drain: rvalid=%b busy=%b want 0", nm, rvalid, busy);
        end
    endtask

    task automatic test_wrap();
        send_line(6'd16, 1'b1, 2, "wrap16");
    endtask

    task automatic test_linear();
        send_line(6'd40, 1'b0, 0, "linear40");
    endtask

    task automatic test_wrap_lowbits();
        send_line(6'd63, 1'b1, 7, "wrap63");
    endtask

    task automatic test_backpressure();
        int hs_n;
        int exp_idx;
        logic r;
        @(negedge clk);
        wrap_mode = 1'b1;
        fifo_rdata = {6'd24, mk_line()};
        fifo_empty = 1'b0;
        rready = 1'b0;
        #1;
        total++;
        if (fifo_rden !== 1'b1) begin
            bad++; $display("FAIL bp_pop: rden=%b want 1", fifo_rden);
        end
        hs_n = 0;
        for (int c = 0; c < 40 && hs_n < NB; c++) begin
            @(negedge clk);
            fifo_rdata = {6'd56, mk_line()};
            fifo_empty = 1'b0;
            r = (c % 4 == 0) || (c % 4 == 3);
            rready = r;
            #1;
            exp_idx = (3 + hs_n) % NB;
            total++;
            if (rvalid !== 1'b1 || rdata !== BW'(exp_idx) || rlast !== (hs_n == NB - 1)
                || fifo_rden !== (r && hs_n == NB - 1)) begin
                bad++;
                $display("FAIL bp_cycle%0d: v=%b data=%0h last=%b rden=%b want 1/%0h/%b/%b",
                         c, rvalid, rdata, rlast, fifo_rden, exp_idx, (hs_n == NB - 1),
                         (r && hs_n == NB - 1));
            end
            if (r) hs_n++;
        end
        total++;
        if (hs_n != NB) begin
            bad++; $display("FAIL bp_handshakes: got %0d want %0d", hs_n, NB);
        end
        @(negedge clk);
        fifo_empty = 1'b1;
        rready = 1'b1;
        #1;
        total++;
        if (rvalid !== 1'b1 || rdata !== BW'(7)) begin
            bad++; $display("FAIL bp_next_line: v=%b data=%0h want 1/7", rvalid, rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int exp_idx;
        @(negedge clk);
        wrap_mode = 1'b1;
        fifo_rdata = {6'd0, mk_line()};
        fifo_empty = 1'b0;
        rready = 1'b1;
        #1;
        total++;
        if (fifo_rden !== 1'b1) begin
            bad++; $display("FAIL b2b_pop0: rden=%b want 1", fifo_rden);
        end
        for (int c = 0; c < 2 * NB; c++) begin
            @(negedge clk);
            fifo_rdata = {6'd32, mk_line()};
            fifo_empty = (c >= NB);
            #1;
            exp_idx = (c < NB) ? c : (4 + c - NB) % NB;
            total++;
            if (rvalid !== 1'b1 || rdata !== BW'(exp_idx)
                || rlast !== (c == NB - 1 || c == 2 * NB - 1) || fifo_rden !== (c == NB - 1)) begin
                bad++;
                $display("FAIL b2b_cycle%0d: v=%b data=%0h last=%b rden=%b want 1/%0h/%b/%b",
                         c, rvalid, rdata, rlast, fifo_rden, exp_idx,
                         (c == NB - 1 || c == 2 * NB - 1), (c == NB - 1));
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (rvalid !== 1'b0) begin
            bad++; $display("FAIL b2b_drain: rvalid=%b want 0", rvalid);
        end
    endtask

    task automatic test_reset_midburst();
        @(negedge clk);
        wrap_mode = 1'b0;
        fifo_rdata = {6'd0, mk_line()};
        fifo_empty = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            fifo_empty = 1'b1;
            #1;
            total++;
            if (rvalid !== 1'b1 || rdata !== BW'(i)) begin
                bad++; $display("FAIL rst_pre%0d: v=%b data=%0h want 1/%0h", i, rvalid, rdata, i);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        fifo_empty = 1'b0;
        #1;
        total++;
        if (fifo_rden !== 1'b0) begin
            bad++; $display("FAIL rst_nopop: rden=%b want 0", fifo_rden);
        end
        @(negedge clk);
        rst = 1'b0;
        fifo_empty = 1'b1;
        #1;
        total++;
        if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0) begin
            bad++; $display("FAIL rst_after: v=%b last=%b data=%0h want 0/0/0", rvalid, rlast, rdata);
        end
        @(negedge clk);
        #1;
        total++;
        if (rvalid !== 1'b0) begin
            bad++; $display("FAIL rst_residual: rvalid=%b want 0", rvalid);
        end
        send_line(6'd8, 1'b1, 1, "rst_restart");
    endtask

    task automatic test_small_config();
        int exp_idx;
        @(negedge clk);
        wrap_mode2 = 1'b1;
        fifo_rdata2 = {4'd12, mk_line2()};
        fifo_empty2 = 1'b0;
        rready2 = 1'b1;
        #1;
        total++;
        if (fifo_rden2 !== 1'b1) begin
            bad++; $display("FAIL cfg2_pop: rden=%b want 1", fifo_rden2);
        end
        for (int i = 0; i < NB2; i++) begin
            @(negedge clk);
            fifo_empty2 = 1'b1;
            #1;
            exp_idx = (3 + i) % NB2;
            total++;
            if (rvalid2 !== 1'b1 || rdata2 !== BW2'(exp_idx) || rlast2 !== (i == NB2 - 1)) begin
                bad++;
                $display("FAIL cfg2_beat%0d: v=%b data=%0h last=%b want 1/%0h/%b",
                         i, rvalid2, rdata2, rlast2, exp_idx, (i == NB2 - 1));
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (rvalid2 !== 1'b0) begin
            bad++; $display("FAIL cfg2_drain: rvalid=%b want 0", rvalid2);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_linear();
        test_wrap_lowbits();
        test_backpressure();
        test_back_to_back();
        test_reset_midburst();
        test_small_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
